// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared controller state encoding and counter sizing for the divider
package div_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/div_param_datapath.sv
// rtl/div_param_datapath.sv - restoring shift-subtract datapath with sign fix-up and result registers
module div_param_datapath
  import div_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int SIGNED = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic             fix,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             cnt_zero,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = cnt_w(WIDTH);

  logic [WIDTH-1:0] a_q, q_q, b_q, dvd_q;
  logic [CNT_W-1:0] cnt;
  logic             sign_q, sign_r, dbz;
  logic             sa, sb, age_b;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   shifted, trial;

  // Magnitudes fit in WIDTH bits as unsigned, including |MIN| = 2^(WIDTH-1).
  always_comb begin
    sa      = (SIGNED != 0) && dividend[WIDTH-1];
    sb      = (SIGNED != 0) && divisor[WIDTH-1];
    abs_a   = sa ? -dividend : dividend;
    abs_b   = sb ? -divisor : divisor;
    shifted = {a_q, q_q[WIDTH-1]};
    trial   = shifted - {1'b0, b_q};
    // Partial remainder stays below 2*|divisor|, so the borrow bit alone decides A >= |divisor|.
    age_b   = ~trial[WIDTH];
  end

  // High on the iteration that takes the counter to zero.
  assign cnt_zero = (cnt == CNT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q         <= '0;
      q_q         <= '0;
      b_q         <= '0;
      dvd_q       <= '0;
      cnt         <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      dbz         <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      if (load) begin
        a_q    <= '0;
        q_q    <= abs_a;
        b_q    <= abs_b;
        dvd_q  <= dividend;
        sign_q <= sa ^ sb;
        sign_r <= sa;
        dbz    <= (divisor == '0);
        cnt    <= CNT_W'(WIDTH);
      end else if (shift) begin
        a_q <= age_b ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
        q_q <= {q_q[WIDTH-2:0], age_b};
        cnt <= cnt - CNT_W'(1);
      end
      if (fix) begin
        quotient    <= dbz ? '1 : (sign_q ? -q_q : q_q);
        remainder   <= dbz ? dvd_q : (sign_r ? -a_q : a_q);
        div_by_zero <= dbz;
      end
    end
  end

endmodule

// File: rtl/div_param_dp_ctrl.sv
// rtl/div_param_dp_ctrl.sv - sequential divider top: controller FSM driving the shift-subtract datapath
module div_param_dp_ctrl
  import div_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int SIGNED = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  state_t state;
  logic   load, shift, fix, cnt_zero;

  assign load  = (state == S_IDLE) && start;
  assign shift = (state == S_ITER);
  assign fix   = (state == S_FIX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          state <= S_ITER;
          busy  <= 1'b1;
        end
        S_ITER: if (cnt_zero) state <= S_FIX;
        S_FIX: begin
          state <= S_DONE;
          done  <= 1'b1;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  div_param_datapath #(
    .WIDTH (WIDTH),
    .SIGNED(SIGNED)
  ) u_datapath (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .shift      (shift),
    .fix        (fix),
    .dividend   (dividend),
    .divisor    (divisor),
    .cnt_zero   (cnt_zero),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

endmodule

// File: tb/tb_div_param_dp_ctrl.sv
// tb/tb_div_param_dp_ctrl.sv - directed self-checking bench for unsigned and signed divider instances
module tb_div_param_dp_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_u = 1'b0, start_s = 1'b0;
  logic [15:0] dividend = '0, divisor = '0;
  logic        busy_u, done_u, dbz_u, busy_s, done_s, dbz_s;
  logic [15:0] quo_u, rem_u, quo_s, rem_s;
  int          n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  div_param_dp_ctrl #(.WIDTH(16), .SIGNED(0)) dut_u (
    .clk(clk), .rst(rst), .start(start_u), .dividend(dividend), .divisor(divisor),
    .busy(busy_u), .done(done_u), .quotient(quo_u), .remainder(rem_u), .div_by_zero(dbz_u)
  );

  div_param_dp_ctrl #(.WIDTH(16), .SIGNED(1)) dut_s (
    .clk(clk), .rst(rst), .start(start_s), .dividend(dividend), .divisor(divisor),
    .busy(busy_s), .done(done_s), .quotient(quo_s), .remainder(rem_s), .div_by_zero(dbz_s)
  );

  // Runs one operation on the selected instance; lat counts cycles after the accept cycle.
  task automatic run_op(input bit sgn, input logic [15:0] a, input logic [15:0] b,
                        output logic [15:0] q, output logic [15:0] r, output logic z,
                        output int lat, output int busy_pre);
    lat = 0; busy_pre = 0; q = 'x; r = 'x; z = 1'bx;
    @(negedge clk);
    dividend = a; divisor = b;
    if (sgn) start_s = 1'b1; else start_u = 1'b1;
    @(posedge clk); #1;
    start_s = 1'b0; start_u = 1'b0;
    dividend = 16'($urandom); divisor = 16'($urandom);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (sgn ? done_s : done_u) begin
        lat = c;
        q = sgn ? quo_s : quo_u;
        r = sgn ? rem_s : rem_u;
        z = sgn ? dbz_s : dbz_u;
        break;
      end
      if (sgn ? busy_s : busy_u) busy_pre++;
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    n_cmp++; if ({busy_u, done_u, dbz_u} !== 3'b000) begin n_bad++; $display("FAIL reset_flags_u got %b want 000", {busy_u, done_u, dbz_u}); end
    n_cmp++; if ({quo_u, rem_u} !== 32'h0) begin n_bad++; $display("FAIL reset_results_u got %h want 0", {quo_u, rem_u}); end
    n_cmp++; if ({busy_s, done_s, dbz_s, quo_s, rem_s} !== 35'h0) begin n_bad++; $display("FAIL reset_s got %h want 0", {busy_s, done_s, dbz_s, quo_s, rem_s}); end
    rst = 1'b0;
  endtask

  task automatic test_unsigned;
    logic [15:0] q, r; logic z; int lat, bp;
    run_op(1'b0, 16'd100, 16'd7, q, r, z, lat, bp);
    n_cmp++; if (lat !== 18) begin n_bad++; $display("FAIL u100_7_latency got %0d want 18", lat); end
    n_cmp++; if (bp !== 17) begin n_bad++; $display("FAIL u100_7_busy_before_done got %0d want 17", bp); end
    n_cmp++; if ({q, r, z} !== {16'd14, 16'd2, 1'b0}) begin n_bad++; $display("FAIL u100_7 got q=%0d r=%0d z=%b want q=14 r=2 z=0", q, r, z); end
    n_cmp++; if (busy_u !== 1'b1) begin n_bad++; $display("FAIL busy_in_done_cycle got %b want 1", busy_u); end
    @(negedge clk);
    n_cmp++; if ({busy_u, done_u} !== 2'b00) begin n_bad++; $display("FAIL done_one_cycle got busy,done=%b want 00", {busy_u, done_u}); end
    run_op(1'b0, 16'd65535, 16'd1, q, r, z, lat, bp);
    n_cmp++; if ({q, r, z} !== {16'hFFFF, 16'h0, 1'b0}) begin n_bad++; $display("FAIL u65535_1 got q=%h r=%h z=%b want ffff 0000 0", q, r, z); end
  endtask

  task automatic test_signed;
    logic [15:0] q, r; logic z; int lat, bp;
    run_op(1'b1, 16'hFF9C, 16'd7, q, r, z, lat, bp);
    n_cmp++; if ({q, r, z, lat} !== {16'hFFF2, 16'hFFFE, 1'b0, 32'd18}) begin n_bad++; $display("FAIL s_m100_7 got q=%h r=%h z=%b lat=%0d want fff2 fffe 0 18", q, r, z, lat); end
    run_op(1'b1, 16'd100, 16'hFFF9, q, r, z, lat, bp);
    n_cmp++; if ({q, r, z} !== {16'hFFF2, 16'h0002, 1'b0}) begin n_bad++; $display("FAIL s_100_m7 got q=%h r=%h z=%b want fff2 0002 0", q, r, z); end
    run_op(1'b1, 16'hFF9C, 16'hFFF9, q, r, z, lat, bp);
    n_cmp++; if ({q, r} !== {16'd14, 16'hFFFE}) begin n_bad++; $display("FAIL s_m100_m7 got q=%h r=%h want 000e fffe", q, r); end
    run_op(1'b1, 16'h8000, 16'hFFFF, q, r, z, lat, bp);
    n_cmp++; if ({q, r, z} !== {16'h8000, 16'h0, 1'b0}) begin n_bad++; $display("FAIL s_min_m1 got q=%h r=%h z=%b want 8000 0000 0", q, r, z); end
  endtask

  task automatic test_div_zero;
    logic [15:0] q, r; logic z; int lat, bp;
    run_op(1'b0, 16'd1234, 16'd0, q, r, z, lat, bp);
    n_cmp++; if ({q, r, z, lat} !== {16'hFFFF, 16'd1234, 1'b1, 32'd18}) begin n_bad++; $display("FAIL u_dbz got q=%h r=%0d z=%b lat=%0d want ffff 1234 1 18", q, r, z, lat); end
    run_op(1'b1, 16'd1234, 16'd0, q, r, z, lat, bp);
    n_cmp++; if ({q, r, z, lat} !== {16'hFFFF, 16'd1234, 1'b1, 32'd18}) begin n_bad++; $display("FAIL s_dbz got q=%h r=%0d z=%b lat=%0d want ffff 1234 1 18", q, r, z, lat); end
    run_op(1'b0, 16'd9, 16'd3, q, r, z, lat, bp);
    n_cmp++; if ({q, r, z} !== {16'd3, 16'd0, 1'b0}) begin n_bad++; $display("FAIL dbz_clears got q=%0d r=%0d z=%b want 3 0 0", q, r, z); end
  endtask

  task automatic test_ignore_start;
    int lat = 0;
    @(negedge clk);
    dividend = 16'd200; divisor = 16'd3; start_u = 1'b1;
    @(posedge clk); #1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      start_u = 1'b1;
      dividend = 16'd5 + 16'(c); divisor = 16'd1;
      if (done_u) begin lat = c; break; end
    end
    n_cmp++; if ({quo_u, rem_u, lat} !== {16'd66, 16'd2, 32'd18}) begin n_bad++; $display("FAIL ignore_start got q=%0d r=%0d lat=%0d want 66 2 18", quo_u, rem_u, lat); end
    @(negedge clk);
    start_u = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if ({busy_u, done_u, quo_u, rem_u} !== {2'b00, 16'd66, 16'd2}) begin n_bad++; $display("FAIL start_in_done_ignored got busy=%b done=%b q=%0d r=%0d want 0 0 66 2", busy_u, done_u, quo_u, rem_u); end
  endtask

  task automatic test_back_to_back;
    logic [15:0] q, r; logic z; int lat, bp;
    run_op(1'b0, 16'd50, 16'd5, q, r, z, lat, bp);
    n_cmp++; if ({q, r} !== {16'd10, 16'd0}) begin n_bad++; $display("FAIL b2b_first got q=%0d r=%0d want 10 0", q, r); end
    run_op(1'b0, 16'd9, 16'd4, q, r, z, lat, bp);
    n_cmp++; if ({q, r, lat} !== {16'd2, 16'd1, 32'd18}) begin n_bad++; $display("FAIL b2b_second got q=%0d r=%0d lat=%0d want 2 1 18", q, r, lat); end
  endtask

  task automatic test_reset_mid;
    int seen_done = 0;
    @(negedge clk);
    dividend = 16'd777; divisor = 16'd5; start_u = 1'b1;
    @(posedge clk); #1;
    start_u = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if ({busy_u, done_u, dbz_u, quo_u, rem_u} !== 35'h0) begin n_bad++; $display("FAIL reset_mid got busy=%b done=%b z=%b q=%h r=%h want all 0", busy_u, done_u, dbz_u, quo_u, rem_u); end
    rst = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (done_u || busy_u) seen_done++;
    end
    n_cmp++; if (seen_done !== 0) begin n_bad++; $display("FAIL reset_mid_no_done got %0d active cycles want 0", seen_done); end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
